// File: rtl/conv_window_gen.sv
// Zero-padded 3x3 window generator that feeds the convolution kernel from a sync-read pixel memory.
// Optional WINGEN_POS_EN adds o_x/o_y ports carrying the centre coordinate of each emitted window.
`timescale 1ns/1ps
module conv_window_gen #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int DW    = 20,
    parameter int AW    = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_start,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_ird,
    output logic [AW-1:0]            o_iaddr,
    input  logic [DW-1:0]            i_idata,
    output logic                     o_valid,
    output logic [9*DW-1:0]          o_data,
    output logic                     o_sel
`ifdef WINGEN_POS_EN
    ,
    output logic [$clog2(IMG_W)-1:0] o_x,
    output logic [$clog2(IMG_H)-1:0] o_y
`endif
);

    localparam int KW = $clog2(IMG_W + 1);
    localparam int YW = $clog2(IMG_H);
    localparam logic [KW-1:0] K_LAST   = KW'(IMG_W);
    localparam logic [YW-1:0] Y_LAST   = YW'(IMG_H - 1);
    localparam logic [AW-1:0] ROW_STEP = AW'(IMG_W);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t          state_reg, state_next;
    logic [YW-1:0]   y_reg, y_next;
    logic [KW-1:0]   k_reg, k_next;
    logic [1:0]      p_reg, p_next;
    logic [AW-1:0]   base_reg, base_next;
    logic            ird_d_reg;
    logic [DW-1:0]   stage0_reg, stage1_reg, cap;
    logic [DW-1:0]   new_col [3];
    logic [9*DW-1:0] win_reg, win_shift, win_next;
    logic            commit, clear;
    logic            row_ok, ird_next, emit_next;
    logic [AW-1:0]   addr_next;

    // Position counters describe the cycle being entered; outputs are registered from them.
    always_comb begin
        state_next = state_reg;
        y_next     = y_reg;
        k_next     = k_reg;
        p_next     = p_reg;
        base_next  = base_reg;
        case (state_reg)
            IDLE: begin
                if (i_start) begin
                    state_next = RUN;
                    y_next     = '0;
                    k_next     = '0;
                    p_next     = '0;
                    base_next  = '0;
                end
            end
            RUN: begin
                if (p_reg != 2'd2) begin
                    p_next = p_reg + 2'd1;
                end else begin
                    p_next = '0;
                    if (k_reg != K_LAST) begin
                        k_next = k_reg + KW'(1);
                    end else if (y_reg != Y_LAST) begin
                        y_next    = y_reg + YW'(1);
                        k_next    = '0;
                        base_next = base_reg + ROW_STEP;
                    end else begin
                        state_next = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (p_reg != 2'd2) begin
                    p_next = p_reg + 2'd1;
                end else begin
                    p_next     = '0;
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A read that was skipped contributes padding, whatever the memory bus carries.
    assign cap        = ird_d_reg ? i_idata : '0;
    assign new_col[0] = stage0_reg;
    assign new_col[1] = stage1_reg;
    assign new_col[2] = cap;

    assign commit = (p_reg == 2'd0) &&
                    ((state_reg == FLUSH) ||
                     (state_reg == RUN && (y_reg != '0 || k_reg != '0)));
    assign clear  = (state_reg == RUN) && (k_reg == KW'(1));

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_shift
            assign win_shift[(3*gi)*DW   +: DW] = clear ? '0 : win_reg[(3*gi+1)*DW +: DW];
            assign win_shift[(3*gi+1)*DW +: DW] = clear ? '0 : win_reg[(3*gi+2)*DW +: DW];
            assign win_shift[(3*gi+2)*DW +: DW] = new_col[gi];
        end
    endgenerate

    assign win_next = commit ? win_shift : win_reg;

    always_comb begin
        case (p_next)
            2'd0:    row_ok = (y_next != '0);
            2'd2:    row_ok = (y_next != Y_LAST);
            default: row_ok = 1'b1;
        endcase
        ird_next  = (state_next == RUN) && (k_next != K_LAST) && row_ok;
        addr_next = o_iaddr;
        if (ird_next) begin
            addr_next = base_next + AW'(k_next);
            if (p_next == 2'd0) begin
                addr_next = addr_next - ROW_STEP;
            end else if (p_next == 2'd2) begin
                addr_next = addr_next + ROW_STEP;
            end
        end
        emit_next = (p_next != 2'd0) &&
                    ((state_next == FLUSH) ||
                     (state_next == RUN && (k_next >= KW'(2) || (k_next == '0 && y_next != '0))));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= IDLE;
            y_reg      <= '0;
            k_reg      <= '0;
            p_reg      <= '0;
            base_reg   <= '0;
            ird_d_reg  <= 1'b0;
            stage0_reg <= '0;
            stage1_reg <= '0;
            win_reg    <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
            o_ird      <= 1'b0;
            o_iaddr    <= '0;
            o_valid    <= 1'b0;
            o_sel      <= 1'b0;
            o_data     <= '0;
        end else begin
            state_reg <= state_next;
            y_reg     <= y_next;
            k_reg     <= k_next;
            p_reg     <= p_next;
            base_reg  <= base_next;
            ird_d_reg <= o_ird;
            if (state_reg == RUN || state_reg == FLUSH) begin
                if (p_reg == 2'd1) stage0_reg <= cap;
                if (p_reg == 2'd2) stage1_reg <= cap;
            end
            win_reg <= win_next;
            o_busy  <= (state_next == RUN) || (state_next == FLUSH);
            o_done  <= (state_next == DONE);
            o_ird   <= ird_next;
            o_iaddr <= addr_next;
            o_valid <= emit_next;
            o_sel   <= emit_next && (p_next == 2'd2);
            if (emit_next && p_next == 2'd1) o_data <= win_next;
        end
    end

`ifdef WINGEN_POS_EN
    logic [$clog2(IMG_W)-1:0] px_next;
    logic [$clog2(IMG_H)-1:0] py_next;

    // Period 0 of a row (and the flush) still emits the last window of the previous row.
    always_comb begin
        if (state_next == FLUSH) begin
            px_next = $bits(px_next)'(IMG_W - 1);
            py_next = $bits(py_next)'(IMG_H - 1);
        end else if (k_next == '0) begin
            px_next = $bits(px_next)'(IMG_W - 1);
            py_next = y_next - YW'(1);
        end else begin
            px_next = $bits(px_next)'(k_next - KW'(2));
            py_next = y_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_x <= '0;
            o_y <= '0;
        end else if (emit_next && p_next == 2'd1) begin
            o_x <= px_next;
            o_y <= py_next;
        end
    end
`endif

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized self-checking bench for conv_window_gen on a 4x4 image with a sync-read memory model.
// Expected activity per cycle is derived arithmetically from the cycle number and the image contents.
`timescale 1ns/1ps
module tb_conv_window_gen;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 20;
    localparam int AW = 4;
    localparam int RUN_CYC  = H * (W + 1) * 3;
    localparam int DONE_CYC = 1 + RUN_CYC + 3;

    typedef logic [9*DW-1:0] word_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              i_start;
    logic              o_busy, o_done, o_ird, o_valid, o_sel;
    logic [AW-1:0]     o_iaddr;
    logic [DW-1:0]     i_idata = '0;
    logic [9*DW-1:0]   o_data;
`ifdef WINGEN_POS_EN
    logic [$clog2(W)-1:0] o_x;
    logic [$clog2(H)-1:0] o_y;
`endif

    logic [DW-1:0] mem [W*H];
    int vectors    = 0;
    int miscompares = 0;
    int cur_cyc    = 0;

    conv_window_gen #(.IMG_W(W), .IMG_H(H), .DW(DW), .AW(AW)) dut (
        .clk     (clk),
        .reset   (reset),
        .i_start (i_start),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_ird   (o_ird),
        .o_iaddr (o_iaddr),
        .i_idata (i_idata),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_sel   (o_sel)
`ifdef WINGEN_POS_EN
        ,
        .o_x     (o_x),
        .o_y     (o_y)
`endif
    );

    always #5 clk = ~clk;

    // Sync-read memory; the bus carries junk whenever no read was issued.
    always @(posedge clk) begin
        if (o_ird) i_idata <= mem[o_iaddr];
        else       i_idata <= DW'($urandom);
    end

    task automatic check(input string tag, input word_t got, input word_t exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cur_cyc, got, exp);
        end
    endtask

    function automatic word_t exp_window(input int y, input int x);
        word_t w;
        int yy, xx;
        w = '0;
        for (int ky = 0; ky < 3; ky++) begin
            for (int kx = 0; kx < 3; kx++) begin
                yy = y + ky - 1;
                xx = x + kx - 1;
                if (yy >= 0 && yy < H && xx >= 0 && xx < W)
                    w[(3*ky+kx)*DW +: DW] = mem[yy*W + xx];
            end
        end
        return w;
    endfunction

    // Cycle c counts from the first RUN cycle (c=1) after the start edge.
    task automatic monitor(input int c);
        int q, per, ph, ey, ex, k, row, s;
        logic eird, ev;
        int eaddr;
        cur_cyc = c;
        eird  = 1'b0;
        eaddr = 0;
        if (c >= 1 && c <= RUN_CYC) begin
            q   = c - 1;
            per = q / 3;
            ph  = q % 3;
            ey  = per / (W + 1);
            k   = per % (W + 1);
            row = ey - 1 + ph;
            if (k < W && row >= 0 && row < H) begin
                eird  = 1'b1;
                eaddr = row * W + k;
            end
        end
        check("ird", word_t'(o_ird), word_t'(eird));
        if (eird) check("iaddr", word_t'(o_iaddr), word_t'(eaddr));
        ev = 1'b0;
        s  = 0;
        ey = 0;
        ex = 0;
        if (c >= 2) begin
            q   = c - 2;
            s   = q % 3;
            per = q / 3 - 2;
            if (s < 2 && per >= 0) begin
                ey = per / (W + 1);
                ex = per % (W + 1);
                if (ex < W && ey < H) ev = 1'b1;
            end
        end
        check("valid", word_t'(o_valid), word_t'(ev));
        check("sel", word_t'(o_sel), word_t'(ev && s == 1));
        if (ev) begin
            check("data", o_data, exp_window(ey, ex));
`ifdef WINGEN_POS_EN
            check("pos_x", word_t'(o_x), word_t'(ex));
            check("pos_y", word_t'(o_y), word_t'(ey));
`endif
        end
        check("busy", word_t'(o_busy), word_t'(c >= 1 && c < DONE_CYC));
        check("done", word_t'(o_done), word_t'(c == DONE_CYC));
    endtask

    task automatic run(input int abort_at, input int spur_at);
        int  nvalid;
        logic aborted;
        nvalid  = 0;
        aborted = 1'b0;
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        for (int c = 1; c <= DONE_CYC + 2; c++) begin
            if (c == abort_at) begin
                cur_cyc = c;
                reset = 1'b1;
                #1;
                check("abort_valid", word_t'(o_valid), '0);
                check("abort_sel", word_t'(o_sel), '0);
                check("abort_busy", word_t'(o_busy), '0);
                check("abort_ird", word_t'(o_ird), '0);
                check("abort_iaddr", word_t'(o_iaddr), '0);
                check("abort_data", o_data, '0);
                @(negedge clk);
                reset = 1'b0;
                for (int i = 0; i < DONE_CYC; i++) begin
                    @(negedge clk);
                    cur_cyc = c + 1 + i;
                    check("abort_done", word_t'(o_done), '0);
                    check("abort_idle", word_t'(o_busy | o_valid | o_ird), '0);
                end
                aborted = 1'b1;
                break;
            end
            monitor(c);
            if (o_valid) nvalid++;
            i_start = (c == spur_at);
            @(negedge clk);
        end
        i_start = 1'b0;
        if (!aborted) check("nvalid", word_t'(nvalid), word_t'(2 * W * H));
    endtask

    task automatic fill_ramp();
        for (int a = 0; a < W*H; a++) mem[a] = DW'(a + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset   = 1'b1;
        i_start = 1'b0;
        fill_ramp();
        #1;
        check("rst_valid", word_t'(o_valid), '0);
        check("rst_sel", word_t'(o_sel), '0);
        check("rst_busy", word_t'(o_busy), '0);
        check("rst_done", word_t'(o_done), '0);
        check("rst_iaddr", word_t'(o_iaddr), '0);
        check("rst_data", o_data, '0);
        repeat (3) begin
            @(negedge clk);
            i_start = 1'b1;
            check("rst_ird", word_t'(o_ird), '0);
            check("rst_hold_busy", word_t'(o_busy), '0);
        end
        i_start = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        run(0, 0);
        mem[5] = 20'hFFFFF;
        run(0, 0);
        fill_ramp();
        run(30, 0);
        run(0, 0);
        run(0, 20);

        for (int r = 0; r < 5; r++) begin
            for (int a = 0; a < W*H; a++) mem[a] = DW'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            if (r == 3) run($urandom_range(5, DONE_CYC - 1), 0);
            else        run(0, $urandom_range(2, RUN_CYC));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
